// File: rtl/physical_idelay_tab_ctrl.sv
// IDELAYE2 tap stepper: LD reload, single-tap steps with settle time,
// and lock status against the registered calibration target.
module physical_idelay_tab_ctrl #(
  parameter int INIT_TAB     = 0,
  parameter int SETTLE_WIDTH = 4
) (
  input  logic       i_clk,
  input  logic       local_arst_n,
  input  logic       i_idelayctrl_rdy,
  input  logic [4:0] i_tab_target,
  input  logic       i_hold,
  output logic       o_idelay_ld,
  output logic       o_idelay_ce,
  output logic       o_idelay_inc,
  output logic [4:0] o_tab_current,
  output logic       o_busy,
  output logic       o_locked
);

  localparam logic [4:0] INIT_V = 5'(INIT_TAB);

  localparam int I_WAIT   = 0;
  localparam int I_LOAD   = 1;
  localparam int I_SETTLE = 2;
  localparam int I_IDLE   = 3;
  localparam int I_STEP   = 4;

  typedef enum logic [4:0] {
    S_WAIT_RDY = 5'b00001,
    S_LOAD     = 5'b00010,
    S_SETTLE   = 5'b00100,
    S_IDLE     = 5'b01000,
    S_STEP     = 5'b10000
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    rdy_m;
  logic                    rdy_s;
  logic [4:0]              r_target;
  logic                    r_hold;
  logic [SETTLE_WIDTH-1:0] cnt_q;
  logic                    dir_q;
  logic [4:0]              tab_q;
  logic                    mismatch;
  logic                    go_step;

  assign mismatch = (r_target != tab_q);
  assign go_step  = state_q[I_IDLE] &&
                    state_d[I_STEP];

  // Two-flop synchroniser for IDELAYCTRL RDY
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= i_idelayctrl_rdy;
      rdy_s <= rdy_m;
    end
  end

  // Register target and hold requests once
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_target <= 5'd0;
      r_hold   <= 1'b0;
    end else begin
      r_target <= i_tab_target;
      r_hold   <= i_hold;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      state_q <= S_WAIT_RDY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; loss of RDY overrides everything
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[I_WAIT]: begin
        if (rdy_s) state_d = S_LOAD;
      end
      state_q[I_LOAD]: begin
        state_d = S_SETTLE;
      end
      state_q[I_SETTLE]: begin
        if (&cnt_q) state_d = S_IDLE;
      end
      state_q[I_IDLE]: begin
        if (!r_hold && mismatch)
          state_d = S_STEP;
      end
      state_q[I_STEP]: begin
        state_d = S_SETTLE;
      end
      default: begin
        state_d = S_WAIT_RDY;
      end
    endcase
    if (!rdy_s) state_d = S_WAIT_RDY;
  end

  // Settle counter runs only while settling
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      cnt_q <= '0;
    end else if (state_q[I_SETTLE]) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Latch step direction on the IDLE decision
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      dir_q <= 1'b0;
    end else if (go_step) begin
      dir_q <= (r_target > tab_q);
    end
  end

  // Track the tap value applied in the IDELAY
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      tab_q <= INIT_V;
    end else if (state_q[I_LOAD]) begin
      tab_q <= INIT_V;
    end else if (state_q[I_STEP]) begin
      if (dir_q) tab_q <= tab_q + 5'd1;
      else       tab_q <= tab_q - 5'd1;
    end
  end

  assign o_idelay_ld   = state_q[I_LOAD];
  assign o_idelay_ce   = state_q[I_STEP];
  assign o_idelay_inc  = state_q[I_STEP] & dir_q;
  assign o_tab_current = tab_q;
  assign o_busy        = ~state_q[I_IDLE];
  assign o_locked      = state_q[I_IDLE] & ~mismatch;

endmodule

// File: tb/tb_physical_idelay_tab_ctrl.sv
// Directed bench for physical_idelay_tab_ctrl: vector table of
// target moves plus hand sequences for hold, RDY loss and reset.
module tb_physical_idelay_tab_ctrl;

  logic       i_clk = 1'b0;
  logic       local_arst_n;
  logic       rdy;
  logic [4:0] target;
  logic       hold;
  logic       ld;
  logic       ce;
  logic       inc;
  logic [4:0] tab;
  logic       busy;
  logic       locked;

  always #5 i_clk = ~i_clk;

  physical_idelay_tab_ctrl #(
    .INIT_TAB    (0),
    .SETTLE_WIDTH(4)
  ) dut (
    .i_clk           (i_clk),
    .local_arst_n    (local_arst_n),
    .i_idelayctrl_rdy(rdy),
    .i_tab_target    (target),
    .i_hold          (hold),
    .o_idelay_ld     (ld),
    .o_idelay_ce     (ce),
    .o_idelay_inc    (inc),
    .o_tab_current   (tab),
    .o_busy          (busy),
    .o_locked        (locked)
  );

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int ld_tot   = 0;
  int ce_tot   = 0;
  int up_tot   = 0;
  int both_tot = 0;
  int jump_tot = 0;
  int ce_q[$];
  logic [4:0] prev_tab = 5'd0;
  logic       prev_ld  = 1'b0;

  function automatic int adiff(
    input logic [4:0] a,
    input logic [4:0] b
  );
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  // Passive monitor: pulse counts, CE timestamps, tap jumps
  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (ld) ld_tot <= ld_tot + 1;
    if (ce) begin
      ce_tot <= ce_tot + 1;
      ce_q.push_back(cyc);
      if (inc) up_tot <= up_tot + 1;
    end
    if (ce && ld) both_tot <= both_tot + 1;
    if (local_arst_n && !prev_ld &&
        adiff(tab, prev_tab) > 1)
      jump_tot <= jump_tot + 1;
    prev_tab <= tab;
    prev_ld  <= ld;
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  task automatic wait_locked(
    input  int lim,
    output int n
  );
    n = 0;
    while (!locked && n < lim) begin
      step();
      n++;
    end
    chk("lock_wait", int'(locked), 1);
  endtask

  task automatic wait_ce(
    input int base,
    input int k,
    input int lim
  );
    int n;
    n = 0;
    while ((ce_tot - base) < k && n < lim) begin
      step();
      n++;
    end
    chk("ce_wait", ce_tot - base, k);
  endtask

  typedef struct {
    logic [4:0] tgt;
    int         exp_ce;
    int         exp_up;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    int bce;
    int bup;
    int bld;
    int qb;
    int bad;

    vt[0] = '{5'd5,  5,  5};
    vt[1] = '{5'd2,  3,  0};
    vt[2] = '{5'd31, 29, 29};
    vt[3] = '{5'd30, 1,  0};
    vt[4] = '{5'd31, 1,  1};
    vt[5] = '{5'd0,  31, 0};

    local_arst_n = 1'b0;
    rdy          = 1'b0;
    hold         = 1'b0;
    target       = 5'd0;
    step();
    step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_ld", int'(ld), 0);
    chk("rst_ce", int'(ce), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_tab", int'(tab), 0);

    local_arst_n = 1'b1;
    bld = ld_tot;
    repeat (20) step();
    chk("rdy_low_no_ld", ld_tot - bld, 0);
    chk("rdy_low_busy", int'(busy), 1);

    rdy = 1'b1;
    n = 0;
    while (!ld && n < 10) begin
      step();
      n++;
    end
    chk("ld_latency", n, 3);
    wait_locked(40, n);
    chk("settle_len", n, 17);
    chk("ld_once", ld_tot - bld, 1);
    chk("init_tab", int'(tab), 0);

    for (int i = 0; i < 6; i++) begin
      bce = ce_tot;
      bup = up_tot;
      qb  = ce_q.size();
      target = vt[i].tgt;
      step();
      chk($sformatf("v%0d_ce_k", i),
          int'(ce), 0);
      chk($sformatf("v%0d_unlock", i),
          int'(locked), 0);
      step();
      chk($sformatf("v%0d_ce_k1", i),
          int'(ce), 1);
      chk($sformatf("v%0d_inc", i),
          int'(inc), (vt[i].exp_up > 0) ? 1 : 0);
      wait_locked(40 * 18, n);
      chk($sformatf("v%0d_tab", i),
          int'(tab), int'(vt[i].tgt));
      chk($sformatf("v%0d_ce_n", i),
          ce_tot - bce, vt[i].exp_ce);
      chk($sformatf("v%0d_up_n", i),
          up_tot - bup, vt[i].exp_up);
      bad = 0;
      for (int j = qb + 1; j < ce_q.size(); j++)
        if (ce_q[j] - ce_q[j-1] != 18) bad++;
      chk($sformatf("v%0d_gap", i), bad, 0);
    end

    bce = ce_tot;
    bup = up_tot;
    target = 5'd31;
    wait_ce(bce, 2, 100);
    repeat (5) step();
    target = 5'd1;
    step();
    step();
    wait_locked(200, n);
    chk("rev_tab", int'(tab), 1);
    chk("rev_ce", ce_tot - bce, 3);
    chk("rev_up", up_tot - bup, 2);

    bce = ce_tot;
    bup = up_tot;
    hold   = 1'b1;
    target = 5'd4;
    repeat (40) step();
    chk("hold_ce", ce_tot - bce, 0);
    chk("hold_locked", int'(locked), 0);
    chk("hold_busy", int'(busy), 0);
    chk("hold_tab", int'(tab), 1);
    hold = 1'b0;
    step();
    step();
    wait_locked(200, n);
    chk("unhold_tab", int'(tab), 4);
    chk("unhold_ce", ce_tot - bce, 3);
    chk("unhold_up", up_tot - bup, 3);

    bce = ce_tot;
    target = 5'd10;
    wait_ce(bce, 1, 10);
    repeat (3) step();
    hold = 1'b1;
    repeat (40) step();
    chk("midhold_ce", ce_tot - bce, 1);
    chk("midhold_tab", int'(tab), 5);
    chk("midhold_locked", int'(locked), 0);
    hold = 1'b0;
    step();
    step();
    wait_locked(200, n);
    chk("midhold_end", int'(tab), 10);

    bce = ce_tot;
    bld = ld_tot;
    target = 5'd3;
    wait_ce(bce, 1, 10);
    repeat (4) step();
    rdy = 1'b0;
    repeat (4) step();
    chk("rdyloss_busy", int'(busy), 1);
    repeat (20) step();
    chk("rdyloss_ce", ce_tot - bce, 1);
    chk("rdyloss_ld", ld_tot - bld, 0);
    chk("rdyloss_tab", int'(tab), 9);
    rdy = 1'b1;
    n = 0;
    while (!ld && n < 10) begin
      step();
      n++;
    end
    chk("reld_latency", n, 3);
    step();
    chk("reld_tab", int'(tab), 0);
    wait_locked(200, n);
    chk("retrack_tab", int'(tab), 3);
    chk("retrack_ld", ld_tot - bld, 1);
    chk("ld_ce_overlap", both_tot, 0);
    chk("tab_jump", jump_tot, 0);

    target = 5'd8;
    n = 0;
    while (!ce && n < 10) begin
      step();
      n++;
    end
    chk("arst_in_step", int'(ce), 1);
    local_arst_n = 1'b0;
    #1;
    chk("arst_ce", int'(ce), 0);
    chk("arst_ld", int'(ld), 0);
    chk("arst_tab", int'(tab), 0);
    chk("arst_busy", int'(busy), 1);
    chk("arst_locked", int'(locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
